wb_gpio_bank: RTL

//  Parametrised Wishbone GPIO peripheral: one output bank with atomic set/clear/toggle, one input

---
 rtl/wb_gpio_bank.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wb_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module      : wb_gpio_bank
//  Description : Wishbone GPIO peripheral. One output bank with atomic
//                set/clear/toggle, one synchronised input bank with per-bit
//                rise/fall edge detection, write-1-to-clear pending flags
//                and a level interrupt. Registered ack gives one wait state.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_gpio_bank #(
    parameter int                  WIDTH       = 32,
    parameter int                  GPO_BITS    = 16,
    parameter int                  GPI_BITS    = 4,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [GPO_BITS-1:0] GPO_RESET   = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [14:0]         adr_i,
    output logic [WIDTH-1:0]    dat_o,
    input  logic [WIDTH-1:0]    dat_i,
    input  logic                we_i,
    input  logic                stb_i,
    output logic                ack_o,
    output logic [GPO_BITS-1:0] gp_o,
    input  logic [GPI_BITS-1:0] gp_i,
    output logic                irq_o
);

    // Register indices decoded from adr_i[5:2]
    localparam logic [3:0] REG_OUT     = 4'd0;
    localparam logic [3:0] REG_SET     = 4'd1;
    localparam logic [3:0] REG_CLR     = 4'd2;
    localparam logic [3:0] REG_TGL     = 4'd3;
    localparam logic [3:0] REG_IN      = 4'd4;
    localparam logic [3:0] REG_RISE_EN = 4'd5;
    localparam logic [3:0] REG_FALL_EN = 4'd6;
    localparam logic [3:0] REG_PEND    = 4'd7;

    logic                access;
    logic                wr;
    logic [3:0]          reg_sel;

    logic [GPI_BITS-1:0] sync_q [SYNC_STAGES];
    logic [GPI_BITS-1:0] sync_in;
    logic [GPI_BITS-1:0] hist;
    logic [GPI_BITS-1:0] rise;
    logic [GPI_BITS-1:0] fall;
    logic [GPI_BITS-1:0] edge_event;

    logic [GPI_BITS-1:0] rise_en;
    logic [GPI_BITS-1:0] fall_en;
    logic [GPI_BITS-1:0] pend;
    logic [GPI_BITS-1:0] pend_next;
    logic [GPI_BITS-1:0] w1c_mask;

    logic [GPO_BITS-1:0] gpo_next;
    logic [WIDTH-1:0]    rd_data;

    // Address bits outside [5:2] carry no meaning for this block
    logic                unused_bits;
    assign unused_bits = &{1'b0, adr_i[14:6], adr_i[1:0]};

    // An access happens once per strobe: on the edge where ack is still low
    assign access  = stb_i & ~ack_o;
    assign wr      = access & we_i;
    assign reg_sel = adr_i[5:2];

    // Edge detection on the synchronised input against last cycle's value
    assign sync_in    = sync_q[SYNC_STAGES-1];
    assign rise       = sync_in & ~hist;
    assign fall       = ~sync_in & hist;
    assign edge_event = (rise & rise_en) | (fall & fall_en);

    // Write-1-to-clear mask; a new event on the same edge overrides the clear
    always_comb begin
        w1c_mask = '0;
        if (wr && reg_sel == REG_PEND) begin
            w1c_mask = dat_i[GPI_BITS-1:0];
        end
    end

    assign pend_next = (pend & ~w1c_mask) | edge_event;

    // Next output value for the OUT/SET/CLR/TGL read-modify-write paths
    always_comb begin
        gpo_next = gp_o;
        if (wr) begin
            case (reg_sel)
                REG_OUT: gpo_next = dat_i[GPO_BITS-1:0];
                REG_SET: gpo_next = gp_o | dat_i[GPO_BITS-1:0];
                REG_CLR: gpo_next = gp_o & ~dat_i[GPO_BITS-1:0];
                REG_TGL: gpo_next = gp_o ^ dat_i[GPO_BITS-1:0];
                default: gpo_next = gp_o;
            endcase
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_OUT:     rd_data[GPO_BITS-1:0] = gp_o;
            REG_IN:      rd_data[GPI_BITS-1:0] = sync_in;
            REG_RISE_EN: rd_data[GPI_BITS-1:0] = rise_en;
            REG_FALL_EN: rd_data[GPI_BITS-1:0] = fall_en;
            REG_PEND:    rd_data[GPI_BITS-1:0] = pend;
            default:     rd_data = '0;
        endcase
    end

    // Input synchroniser chain for the asynchronous gp_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gp_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Bus handshake, read data and output bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_o <= 1'b0;
            dat_o <= '0;
            gp_o  <= GPO_RESET;
        end else begin
            ack_o <= access;
            gp_o  <= gpo_next;
            if (access) begin
                dat_o <= rd_data;
            end
        end
    end

    // Interrupt enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_en <= '0;
            fall_en <= '0;
        end else if (wr) begin
            if (reg_sel == REG_RISE_EN) rise_en <= dat_i[GPI_BITS-1:0];
            if (reg_sel == REG_FALL_EN) fall_en <= dat_i[GPI_BITS-1:0];
        end
    end

    // Edge history, pending flags and interrupt (irq tracks pend on the same edge)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            pend  <= '0;
            irq_o <= 1'b0;
        end else begin
            hist  <= sync_in;
            pend  <= pend_next;
            irq_o <= |pend_next;
        end
    end

endmodule
`default_nettype wire
